pinball_game_ctrl: RTL and testbench
====================================

Name: pinball_game_ctrl

Overview:
- Top-level game sequencer for the pinball machine.
- Produces the 3-bit game `state` bus that the group-select stage consumes.
- Consumes that stage's `selected_group` result, then scores the shot, tracks remaining balls and a high score, and sequences RESET → WAIT → START → GET → OVER.
- Sits between the debounced button inputs and the group-select, score-display and LED stages.

Parameters:
- BALLS, 3, balls per game (1..7).
- GET_TICKS, 4, number of flash_clk pulses the GET state holds for result display (1..15).
- SCORE_W, 10, width of score and high_score; both saturate at 2^SCORE_W-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- flash_clk  input  1  one-clk-wide enable pulse from the flash divider.
- btn_start  input  1  debounced start button, level.
- btn_down  input  1  debounced shoot button, level (same signal fed to group select).
- selected_group  input  3  group index from group select; 0 = miss.
- state  output  3  RESET=0, WAIT=1, START=2, GET=3, OVER=4.
- score  output  SCORE_W  current game score.
- high_score  output  SCORE_W  best score since reset.
- balls_left  output  3  balls remaining.
- hit_group  output  3  group latched on the last shot.

Behaviour:
- Reset (reset==0, async): state=RESET, score=0, high_score=0, balls_left=0, hit_group=0, tick_cnt=0, edge-detect history regs=0.
- Edge detect: start_p = btn_start & ~btn_start_q; shoot_p = btn_down & ~btn_down_q. Both are registered one-cycle pulses. A held button yields exactly one pulse.
- RESET: unconditionally → WAIT on the next clk.
- WAIT:
  - On start_p: → START; score←0; balls_left←BALLS; hit_group←0.
- START:
  - On shoot_p: → GET; hit_group←selected_group, sampled in the same cycle as shoot_p; tick_cnt←0.
  - Scoring in that same transition cycle:
    - selected_group==0: balls_left←balls_left-1 (miss).
    - Otherwise: score←sat(score + selected_group); balls unchanged.
  - start_p is ignored in START.
- GET:
  - tick_cnt increments on each flash_clk pulse.
  - When tick_cnt==GET_TICKS-1 and flash_clk==1: leave GET.
    - balls_left==0 → OVER, and high_score←max(high_score, score) in the same cycle.
    - Otherwise → START.
  - shoot_p and start_p are ignored in GET.
- OVER:
  - score and hit_group hold.
  - On start_p: → WAIT.
  - The next start_p then begins a new game; high_score is preserved.
- Encodings 5..7 are illegal: → RESET on the next clk.
- Saturation: the score add is computed SCORE_W+1 bits wide; on overflow, clamp to all-ones.
- Simultaneous events:
  - shoot_p coincident with flash_clk in START: the shot is taken using the current selected_group.
  - The last flash_clk of GET coincident with shoot_p: the shot is ignored, and the transition proceeds.
- Reset asserted mid-game (any state): all outputs return to reset values immediately, including high_score.
- All outputs are registered; there is no combinational path from input to output.

Decomposition:
- Shared package `pinball_pkg`:
  - State encodings RESET/WAIT/START/GET/OVER as 3-bit localparams, identical to those used by group select.
  - Group width constant GROUP_W=3.
- One natural sub-module: `btn_edge` (2-flop pulse generator with async active-low reset), instantiated twice, for btn_start and btn_down.

Test Plan:
- Reset release then idle → state 0 for one clk, then 1; all other outputs 0.
- WAIT, btn_start held 20 clks → single transition to START; balls_left=3, score=0; state remains 2 after release.
- START, selected_group=5, btn_down rises → next clk state=3, hit_group=5, score=5. After 4 flash_clk pulses → state=2; balls_left still 3.
- Three shots with selected_group=0 → balls_left 3→2→1→0. After the last GET hold → state=4, high_score=prior score (e.g. 5). A further btn_start → state=1, with high_score retained.
- SCORE_W=4 override: shots of 7, 7, 7 → score 7, 14, then 15 (saturated, not 5).
- Reset pulled low during GET with score=12 → all outputs 0 asynchronously; after release, state 0 → 1.

Source files
------------

// File: rtl/pinball_pkg.sv
// Shared encodings for the pinball game sequencer and the group-select stage.
package pinball_pkg;

  localparam int GROUP_W = 3;

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_GET   = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  typedef enum logic [2:0] {
    GS_RESET = ST_RESET,
    GS_WAIT  = ST_WAIT,
    GS_START = ST_START,
    GS_GET   = ST_GET,
    GS_OVER  = ST_OVER
  } game_state_e;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge pulse generator for a debounced level button; a held button gives one pulse.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic btn_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      btn_q <= btn;
      pulse <= btn & ~btn_q;
    end
  end

endmodule

// File: rtl/pinball_game_ctrl.sv
// Pinball game sequencer: start/shoot handling, scoring, ball count, high score and
// the game state bus consumed by group select.
module pinball_game_ctrl
  import pinball_pkg::*;
#(
  parameter int BALLS     = 3,
  parameter int GET_TICKS = 4,
  parameter int SCORE_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flash_clk,
  input  logic               btn_start,
  input  logic               btn_down,
  input  logic [GROUP_W-1:0] selected_group,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [2:0]         balls_left,
  output logic [GROUP_W-1:0] hit_group
);

  localparam logic [3:0] TICK_LAST = 4'(GET_TICKS - 1);

  game_state_e        state_reg;
  logic [3:0]         tick_cnt;
  logic               start_p;
  logic               shoot_p;
  logic [SCORE_W:0]   sum_wide;
  logic [SCORE_W-1:0] score_sat;

  btn_edge u_start_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start),
    .pulse (start_p)
  );

  btn_edge u_shoot_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_down),
    .pulse (shoot_p)
  );

  // One extra bit catches the carry so the score clamps instead of wrapping.
  assign sum_wide  = {1'b0, score} + (SCORE_W + 1)'(selected_group);
  assign score_sat = sum_wide[SCORE_W] ? '1 : sum_wide[SCORE_W-1:0];

  assign state = state_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= GS_RESET;
      score      <= '0;
      high_score <= '0;
      balls_left <= '0;
      hit_group  <= '0;
      tick_cnt   <= '0;
    end else begin
      case (state_reg)
        GS_RESET: state_reg <= GS_WAIT;

        GS_WAIT: begin
          if (start_p) begin
            state_reg  <= GS_START;
            score      <= '0;
            balls_left <= 3'(BALLS);
            hit_group  <= '0;
          end
        end

        GS_START: begin
          if (shoot_p) begin
            state_reg <= GS_GET;
            hit_group <= selected_group;
            tick_cnt  <= '0;
            if (selected_group == '0) begin
              balls_left <= balls_left - 3'd1;
            end else begin
              score <= score_sat;
            end
          end
        end

        GS_GET: begin
          if (flash_clk) begin
            if (tick_cnt == TICK_LAST) begin
              if (balls_left == 3'd0) begin
                state_reg <= GS_OVER;
                if (score > high_score) begin
                  high_score <= score;
                end
              end else begin
                state_reg <= GS_START;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        GS_OVER: begin
          if (start_p) begin
            state_reg <= GS_WAIT;
          end
        end

        default: state_reg <= GS_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_pinball_game_ctrl.sv
// Directed bench for pinball_game_ctrl: a default instance plus a SCORE_W=4 instance
// sharing stimulus, with expected snapshots queued at stimulus time and checked later.
module tb_pinball_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flash_clk = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_down = 1'b0;
  logic [2:0] selected_group = 3'd0;

  logic [2:0] state, state4;
  logic [9:0] score, high_score;
  logic [3:0] score4, high_score4;
  logic [2:0] balls_left, balls_left4;
  logic [2:0] hit_group, hit_group4;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [9:0] sc;
    logic [9:0] hs;
    logic [2:0] bl;
    logic [2:0] hg;
    logic [3:0] sc4;
  } snap_t;

  snap_t exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  pinball_game_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .flash_clk      (flash_clk),
    .btn_start      (btn_start),
    .btn_down       (btn_down),
    .selected_group (selected_group),
    .state          (state),
    .score          (score),
    .high_score     (high_score),
    .balls_left     (balls_left),
    .hit_group      (hit_group)
  );

  pinball_game_ctrl #(.SCORE_W(4)) dut4 (
    .clk            (clk),
    .reset          (reset),
    .flash_clk      (flash_clk),
    .btn_start      (btn_start),
    .btn_down       (btn_down),
    .selected_group (selected_group),
    .state          (state4),
    .score          (score4),
    .high_score     (high_score4),
    .balls_left     (balls_left4),
    .hit_group      (hit_group4)
  );

  task automatic expect_snap(input string tag, input logic [2:0] st, input logic [9:0] sc,
                             input logic [9:0] hs, input logic [2:0] bl, input logic [2:0] hg,
                             input logic [3:0] sc4);
    snap_t s;
    s.st = st; s.sc = sc; s.hs = hs; s.bl = bl; s.hg = hg; s.sc4 = sc4;
    exp_q.push_back(s);
    tag_q.push_back(tag);
  endtask

  task automatic check_snap();
    snap_t e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (state === e.st) else begin
      bad++; $error("FAIL %s state got=%0d want=%0d", t, state, e.st);
    end
    total++;
    assert (score === e.sc) else begin
      bad++; $error("FAIL %s score got=%0d want=%0d", t, score, e.sc);
    end
    total++;
    assert (high_score === e.hs) else begin
      bad++; $error("FAIL %s high_score got=%0d want=%0d", t, high_score, e.hs);
    end
    total++;
    assert (balls_left === e.bl) else begin
      bad++; $error("FAIL %s balls_left got=%0d want=%0d", t, balls_left, e.bl);
    end
    total++;
    assert (hit_group === e.hg) else begin
      bad++; $error("FAIL %s hit_group got=%0d want=%0d", t, hit_group, e.hg);
    end
    total++;
    assert (score4 === e.sc4) else begin
      bad++; $error("FAIL %s score4 got=%0d want=%0d", t, score4, e.sc4);
    end
    $display("txn %-14s state=%0d score=%0d high=%0d balls=%0d hit=%0d score4=%0d",
             t, state, score, high_score, balls_left, hit_group, score4);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press/release start; the FSM acts on the second rising edge after the press.
  task automatic press_start();
    btn_start = 1'b1; cyc(1);
    btn_start = 1'b0; cyc(1);
  endtask

  task automatic shoot(input logic [2:0] g);
    selected_group = g;
    btn_down = 1'b1; cyc(1);
    btn_down = 1'b0; cyc(1);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      flash_clk = 1'b1; cyc(1);
      flash_clk = 1'b0; cyc(1);
    end
  endtask

  initial begin
    cyc(2);
    expect_snap("in_reset", 0, 0, 0, 0, 0, 0);
    check_snap();

    reset = 1'b1;
    #1;
    expect_snap("rel_reset", 0, 0, 0, 0, 0, 0);
    check_snap();
    expect_snap("to_wait", 1, 0, 0, 0, 0, 0);
    cyc(1);
    check_snap();

    // Held start: one pulse only.
    btn_start = 1'b1;
    expect_snap("start_p_lat", 1, 0, 0, 0, 0, 0);
    cyc(1); check_snap();
    expect_snap("in_start", 2, 0, 0, 3, 0, 0);
    cyc(1); check_snap();
    expect_snap("start_held", 2, 0, 0, 3, 0, 0);
    cyc(18); check_snap();
    btn_start = 1'b0;
    expect_snap("start_rel", 2, 0, 0, 3, 0, 0);
    cyc(2); check_snap();
    expect_snap("start_ign", 2, 0, 0, 3, 0, 0);
    press_start(); cyc(1); check_snap();

    expect_snap("hit5", 3, 5, 0, 3, 5, 5);
    shoot(3'd5); check_snap();
    expect_snap("get_shot_ign", 3, 5, 0, 3, 5, 5);
    shoot(3'd6); check_snap();
    expect_snap("get_hold", 3, 5, 0, 3, 5, 5);
    pulses(3); check_snap();
    expect_snap("get_done", 2, 5, 0, 3, 5, 5);
    pulses(1); check_snap();

    expect_snap("miss1", 3, 5, 0, 2, 0, 5);
    shoot(3'd0); check_snap();
    pulses(4);
    expect_snap("miss2", 3, 5, 0, 1, 0, 5);
    shoot(3'd0); check_snap();

    // Last flash pulse lands together with a shoot pulse: shot dropped.
    pulses(3);
    selected_group = 3'd6;
    btn_down = 1'b1; cyc(1);
    flash_clk = 1'b1; cyc(1);
    flash_clk = 1'b0; btn_down = 1'b0;
    expect_snap("coincide", 2, 5, 0, 1, 0, 5);
    check_snap();
    expect_snap("coincide_aft", 2, 5, 0, 1, 0, 5);
    cyc(2); check_snap();

    expect_snap("miss3", 3, 5, 0, 0, 0, 5);
    shoot(3'd0); check_snap();
    expect_snap("game_over", 4, 5, 5, 0, 0, 5);
    pulses(4); check_snap();
    expect_snap("over_wait", 1, 5, 5, 0, 0, 5);
    press_start(); check_snap();
    expect_snap("new_game", 2, 0, 5, 3, 0, 0);
    press_start(); check_snap();

    // Shot taken while a flash pulse arrives in START.
    selected_group = 3'd7;
    btn_down = 1'b1; cyc(1);
    flash_clk = 1'b1; cyc(1);
    flash_clk = 1'b0; btn_down = 1'b0;
    expect_snap("sat7", 3, 7, 5, 3, 7, 7);
    check_snap();
    pulses(4);
    expect_snap("sat14", 3, 14, 5, 3, 7, 14);
    shoot(3'd7); check_snap();
    pulses(4);
    expect_snap("sat15", 3, 21, 5, 3, 7, 15);
    shoot(3'd7); check_snap();

    pulses(1);
    #2 reset = 1'b0;
    #1;
    expect_snap("async_rst", 0, 0, 0, 0, 0, 0);
    check_snap();
    cyc(2);
    reset = 1'b1;
    #1;
    expect_snap("rel2", 0, 0, 0, 0, 0, 0);
    check_snap();
    expect_snap("wait2", 1, 0, 0, 0, 0, 0);
    cyc(1); check_snap();

    total++;
    assert (exp_q.size() == 0) else begin
      bad++; $error("FAIL queue_left got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
